// File: rtl/fft_butterfly_sequencer_if.sv
// Handshake and address bundle between the FFT butterfly sequencer and the
// datapath / sample RAM / twiddle ROM it drives.
//   master : the sequencer (takes start/step controls, drives strobes and addresses)
//   slave  : the datapath side (drives start/step controls, consumes strobes and addresses)
interface fft_butterfly_sequencer_if #(
   parameter int LOG2N = 3
);
   logic             start;
   logic             step_mode;
   logic             step;
   logic             busy;
   logic             done;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             load_W;
   logic             load_B;
   logic             load_A;
   logic [2:0]       op;
   logic             calc_en;
   logic             store_en;
   logic             wr_en;
   logic             wr_sel;
   logic [3:0]       stage;
   logic [LOG2N-2:0] bfly;

   modport master (
      input  start, step_mode, step,
      output busy, done, rd_addr_a, rd_addr_b, tw_addr, load_W, load_B, load_A,
             op, calc_en, store_en, wr_en, wr_sel, stage, bfly
   );

   modport slave (
      output start, step_mode, step,
      input  busy, done, rd_addr_a, rd_addr_b, tw_addr, load_W, load_B, load_A,
             op, calc_en, store_en, wr_en, wr_sel, stage, bfly
   );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// In-place radix-2 DIT FFT controller for 2**LOG2N complex samples.
// Walks every stage and butterfly, generates sample and twiddle addresses,
// and sequences the butterfly datapath micro-ops, with a single-step mode.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - master side of fft_butterfly_sequencer_if (start/step controls in,
//          load/calc/store/write strobes, op, addresses, stage/bfly out)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// LD_W     | datapath registers twiddle W
// LD_B     | datapath registers sample B
// CALC     | calc_en for MUL_LAT cycles on the current op
// STORE    | datapath latches the op result
// LD_A     | datapath registers sample A (between op 2 and op 3)
// WR_Y     | write Y back to rd_addr_a
// WR_Z     | write Z back to rd_addr_b; advances bfly/stage
// HOLD     | single-step pause, waiting for step
// DONE     | one-cycle done pulse, then IDLE
module fft_butterfly_sequencer #(
   parameter int LOG2N   = 3,
   parameter int MUL_LAT = 1
) (
   input logic                     clk,
   input logic                     rst,
   fft_butterfly_sequencer_if.master bus
);

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_LD_W  = 4'd1;
   localparam logic [3:0] ST_LD_B  = 4'd2;
   localparam logic [3:0] ST_CALC  = 4'd3;
   localparam logic [3:0] ST_STORE = 4'd4;
   localparam logic [3:0] ST_LD_A  = 4'd5;
   localparam logic [3:0] ST_WR_Y  = 4'd6;
   localparam logic [3:0] ST_WR_Z  = 4'd7;
   localparam logic [3:0] ST_HOLD  = 4'd8;
   localparam logic [3:0] ST_DONE  = 4'd9;

   localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);
   localparam logic [3:0]       CALC_LAST  = 4'(MUL_LAT - 1);
   localparam logic [LOG2N-2:0] K_ONES     = '1;
   localparam logic [LOG2N-2:0] K_ONE      = (LOG2N - 1)'(1);
   localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);

   logic [3:0]       state;
   logic [3:0]       stage_q;
   logic [LOG2N-2:0] bfly_q;
   logic [2:0]       op_q;
   logic [3:0]       calc_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         stage_q  <= '0;
         bfly_q   <= '0;
         op_q     <= '0;
         calc_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               op_q <= '0;
               if (bus.start) state <= ST_LD_W;
            end
            ST_LD_W: state <= ST_LD_B;
            ST_LD_B: begin
               op_q     <= '0;
               calc_cnt <= '0;
               state    <= ST_CALC;
            end
            ST_CALC: begin
               if (calc_cnt == CALC_LAST) state <= ST_STORE;
               else                       calc_cnt <= calc_cnt + 4'd1;
            end
            ST_STORE: begin
               calc_cnt <= '0;
               if (op_q == 3'd5) begin
                  op_q  <= '0;
                  state <= ST_WR_Y;
               end else begin
                  op_q  <= op_q + 3'd1;
                  // A is only needed for the second half of the micro-ops
                  state <= (op_q == 3'd2) ? ST_LD_A : ST_CALC;
               end
            end
            ST_LD_A: state <= ST_CALC;
            ST_WR_Y: state <= ST_WR_Z;
            ST_WR_Z: begin
               if (bfly_q != K_ONES) begin
                  bfly_q <= bfly_q + K_ONE;
                  state  <= bus.step_mode ? ST_HOLD : ST_LD_W;
               end else if (stage_q == STAGE_LAST) begin
                  bfly_q  <= '0;
                  stage_q <= '0;
                  state   <= ST_DONE;
               end else begin
                  bfly_q  <= '0;
                  stage_q <= stage_q + 4'd1;
                  state   <= bus.step_mode ? ST_HOLD : ST_LD_W;
               end
            end
            ST_HOLD: if (bus.step) state <= ST_LD_W;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Address generation from the registered stage/bfly counters.
   // In LOG2N-1 bits, K_ONES << stage becomes zero at the last stage, so
   // lo_mask covers every bit of k there, as the span-1 mask should.
   logic [LOG2N-2:0] lo_mask;
   logic [LOG2N-2:0] lo;
   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] addr_a;
   logic [LOG2N-1:0] addr_b;
   logic [LOG2N-2:0] tw;
   logic [3:0]       tw_shift;

   always_comb begin
      lo_mask  = ~(K_ONES << stage_q);
      lo       = bfly_q & lo_mask;
      span     = ONE << stage_q;
      addr_a   = (({1'b0, bfly_q} >> stage_q) << (stage_q + 4'd1)) | {1'b0, lo};
      addr_b   = addr_a + span;
      tw_shift = STAGE_LAST - stage_q;
      tw       = lo << tw_shift;
   end

   logic busy_int;
   assign busy_int = (state != ST_IDLE) && (state != ST_DONE);

   assign bus.busy      = busy_int;
   assign bus.done      = (state == ST_DONE);
   // addresses are quiet outside a transform so the idle bus reads all-zero
   assign bus.rd_addr_a = busy_int ? addr_a : '0;
   assign bus.rd_addr_b = busy_int ? addr_b : '0;
   assign bus.tw_addr   = busy_int ? tw : '0;
   assign bus.load_W    = (state == ST_LD_W);
   assign bus.load_B    = (state == ST_LD_B);
   assign bus.load_A    = (state == ST_LD_A);
   assign bus.op        = op_q;
   assign bus.calc_en   = (state == ST_CALC);
   assign bus.store_en  = (state == ST_STORE);
   assign bus.wr_en     = (state == ST_WR_Y) || (state == ST_WR_Z);
   assign bus.wr_sel    = (state == ST_WR_Z);
   assign bus.stage     = stage_q;
   assign bus.bfly      = bfly_q;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Scoreboard bench for fft_butterfly_sequencer: two instances
// (LOG2N=3/MUL_LAT=1 and LOG2N=4/MUL_LAT=3) driven by independent stimulus,
// one monitor comparing write-backs and transform summaries against queues.
module tb_fft_butterfly_sequencer;
   localparam int L0 = 3, M0 = 1, L1 = 4, M1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fft_butterfly_sequencer_if #(.LOG2N(L0)) b0 ();
   fft_butterfly_sequencer_if #(.LOG2N(L1)) b1 ();

   fft_butterfly_sequencer #(.LOG2N(L0), .MUL_LAT(M0)) u0 (.clk(clk), .rst(rst0), .bus(b0));
   fft_butterfly_sequencer #(.LOG2N(L1), .MUL_LAT(M1)) u1 (.clk(clk), .rst(rst1), .bus(b1));

   typedef struct { int sel; int addr; int stage; int bfly; int tw; } wb_t;
   typedef struct { int active; int holds; int wr; int done_rel; } tr_t;

   wb_t q_wb0[$], q_wb1[$];
   tr_t q_tr0[$], q_tr1[$];

   int compared = 0, mismatched = 0;
   int t0[2];
   int act[2], holds[2], wrc[2], run[2], run_op[2], exp_op[2];
   logic prev_calc[2], prev_hold[2], prev_step[2], zchk[2];
   logic fin0 = 1'b0, fin1 = 1'b0;

   function automatic void chk(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   task automatic push_run(input int id, input int lg, input int ml, input bit sm);
      int n, nb, span, g, j;
      wb_t w;
      tr_t t;
      n  = 1 << lg;
      nb = 0;
      for (int s = 0; s < lg; s++) begin
         for (int k = 0; k < n / 2; k++) begin
            span    = 1 << s;
            g       = k / span;
            j       = k % span;
            w.sel   = 0;
            w.addr  = g * 2 * span + j;
            w.stage = s;
            w.bfly  = k;
            w.tw    = j * (n / (2 * span));
            if (id == 0) q_wb0.push_back(w); else q_wb1.push_back(w);
            w.sel  = 1;
            w.addr = w.addr + span;
            if (id == 0) q_wb0.push_back(w); else q_wb1.push_back(w);
            nb++;
         end
      end
      t.active   = nb * (11 + 6 * ml);
      t.holds    = sm ? nb - 1 : 0;
      t.wr       = 2 * nb;
      t.done_rel = sm ? -1 : t.active + 1;
      if (id == 0) q_tr0.push_back(t); else q_tr1.push_back(t);
   endtask

   function automatic void clear_q(input int id);
      if (id == 0) begin q_wb0.delete(); q_tr0.delete(); end
      else begin q_wb1.delete(); q_tr1.delete(); end
   endfunction

   // ---------------- monitor ----------------
   task automatic mon(input int id, ml, r, busy, done, lw, lb, la, op, calc, store, wr, sel,
                      ra, rb, tw, stg, bf, stp);
      wb_t w;
      tr_t t;
      int strobes, sz;
      logic hold;
      string p;
      p = $sformatf("u%0d ", id);
      if (r != 0) begin
         act[id] = 0; holds[id] = 0; wrc[id] = 0; run[id] = 0; exp_op[id] = 0;
         prev_calc[id] = 0; prev_hold[id] = 0; prev_step[id] = 0; zchk[id] = 1;
         return;
      end
      if (zchk[id]) begin
         chk({p, "reset_outputs"},
             busy | done | lw | lb | la | op | calc | store | wr | sel | ra | rb | tw | stg | bf, 0);
         zchk[id] = 0;
      end
      strobes = lw | lb | la | calc | store | wr;
      hold    = (busy != 0) && (strobes == 0);
      if (busy != 0 && strobes != 0) act[id]++;
      if (hold && !prev_hold[id]) holds[id]++;
      if (prev_hold[id]) begin
         if (prev_step[id]) chk({p, "step_release_ld_w"}, lw, 1);
         else               chk({p, "hold_stays"}, int'(hold), 1);
      end
      if (calc != 0) begin
         if (prev_calc[id]) begin
            run[id]++;
            chk({p, "op_stable"}, op, run_op[id]);
         end else begin
            run[id]    = 1;
            run_op[id] = op;
            chk({p, "calc_op"}, op, exp_op[id]);
         end
      end else if (prev_calc[id]) begin
         chk({p, "calc_len"}, run[id], ml);
      end
      if (store != 0) begin
         chk({p, "store_op"}, op, exp_op[id]);
         exp_op[id] = (exp_op[id] + 1) % 6;
      end
      if (wr != 0) begin
         wrc[id]++;
         sz = (id == 0) ? q_wb0.size() : q_wb1.size();
         if (sz == 0) chk({p, "wb_unexpected"}, 1, 0);
         else begin
            if (id == 0) w = q_wb0.pop_front(); else w = q_wb1.pop_front();
            chk({p, "wb_sel"}, sel, w.sel);
            chk({p, "wb_addr"}, (sel != 0) ? rb : ra, w.addr);
            chk({p, "wb_stage"}, stg, w.stage);
            chk({p, "wb_bfly"}, bf, w.bfly);
            chk({p, "wb_tw"}, tw, w.tw);
         end
      end
      if (done != 0) begin
         chk({p, "done_busy"}, busy, 0);
         chk({p, "done_counters"}, stg | bf, 0);
         sz = (id == 0) ? q_tr0.size() : q_tr1.size();
         if (sz == 0) chk({p, "done_unexpected"}, 1, 0);
         else begin
            if (id == 0) t = q_tr0.pop_front(); else t = q_tr1.pop_front();
            chk({p, "active_cycles"}, act[id], t.active);
            chk({p, "hold_count"}, holds[id], t.holds);
            chk({p, "wr_pulses"}, wrc[id], t.wr);
            if (t.done_rel >= 0) chk({p, "done_cycle"}, cyc - t0[id], t.done_rel);
         end
         sz = (id == 0) ? q_wb0.size() : q_wb1.size();
         chk({p, "wb_left"}, sz, 0);
         act[id] = 0; holds[id] = 0; wrc[id] = 0; exp_op[id] = 0;
      end
      prev_calc[id] = (calc != 0);
      prev_hold[id] = hold;
      prev_step[id] = (stp != 0);
   endtask

   always @(negedge clk) begin
      mon(0, M0, int'(rst0), int'(b0.busy), int'(b0.done), int'(b0.load_W), int'(b0.load_B),
          int'(b0.load_A), int'(b0.op), int'(b0.calc_en), int'(b0.store_en), int'(b0.wr_en),
          int'(b0.wr_sel), int'(b0.rd_addr_a), int'(b0.rd_addr_b), int'(b0.tw_addr),
          int'(b0.stage), int'(b0.bfly), int'(b0.step));
      mon(1, M1, int'(rst1), int'(b1.busy), int'(b1.done), int'(b1.load_W), int'(b1.load_B),
          int'(b1.load_A), int'(b1.op), int'(b1.calc_en), int'(b1.store_en), int'(b1.wr_en),
          int'(b1.wr_sel), int'(b1.rd_addr_a), int'(b1.rd_addr_b), int'(b1.tw_addr),
          int'(b1.stage), int'(b1.bfly), int'(b1.step));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drv(input int id, input logic s, input logic st, input logic sm);
      if (id == 0) begin b0.start = s; b0.step = st; b0.step_mode = sm; end
      else begin b1.start = s; b1.step = st; b1.step_mode = sm; end
   endtask

   function automatic logic is_busy(input int id);
      return (id == 0) ? b0.busy : b1.busy;
   endfunction

   function automatic logic is_done(input int id);
      return (id == 0) ? b0.done : b1.done;
   endfunction

   function automatic logic is_calc(input int id);
      return (id == 0) ? b0.calc_en : b1.calc_en;
   endfunction

   function automatic logic is_hold(input int id);
      if (id == 0)
         return b0.busy && !(b0.load_W | b0.load_B | b0.load_A | b0.calc_en | b0.store_en | b0.wr_en);
      return b1.busy && !(b1.load_W | b1.load_B | b1.load_A | b1.calc_en | b1.store_en | b1.wr_en);
   endfunction

   // called while the DUT is idle; returns in the first LD_W cycle
   task automatic go(input int id, input bit sm);
      drv(id, 1'b1, 1'b0, sm);
      t0[id] = cyc;
      push_run(id, (id == 0) ? L0 : L1, (id == 0) ? M0 : M1, sm);
      tick();
      drv(id, 1'b0, 1'b0, sm);
   endtask

   // runs until the done cycle, then returns in the following idle cycle
   task automatic wait_done(input int id, input int limit, input bit sm, input bit noise);
      int n;
      logic s, st;
      n = 0;
      while (!is_done(id) && n < limit) begin
         s  = 1'b0;
         st = 1'b0;
         if (noise && is_busy(id) && $urandom_range(0, 9) == 0) s = 1'b1;
         if (sm && is_hold(id) && $urandom_range(0, 2) == 0) st = 1'b1;
         if (sm && is_calc(id) && $urandom_range(0, 3) == 0) st = 1'b1;
         drv(id, s, st, sm);
         tick();
         n++;
      end
      drv(id, 1'b0, 1'b0, sm);
      if (n >= limit) chk($sformatf("u%0d done_timeout", id), 0, 1);
      tick();
   endtask

   // ---------------- instance 0: directed scenarios ----------------
   initial begin
      drv(0, 1'b0, 1'b0, 1'b0);
      rst0 = 1'b1;
      repeat (3) tick();
      rst0 = 1'b0;
      tick();
      go(0, 1'b0);
      wait_done(0, 2000, 1'b0, 1'b0);
      go(0, 1'b0);
      wait_done(0, 2000, 1'b0, 1'b1);
      go(0, 1'b0);
      wait_done(0, 2000, 1'b0, 1'b0);
      go(0, 1'b1);
      wait_done(0, 5000, 1'b1, 1'b0);
      go(0, 1'b0);
      repeat (49) tick();
      rst0 = 1'b1;
      clear_q(0);
      tick();
      rst0 = 1'b0;
      go(0, 1'b0);
      wait_done(0, 2000, 1'b0, 1'b0);
      fin0 = 1'b1;
   end

   // ---------------- instance 1: randomized runs ----------------
   initial begin
      bit sm;
      drv(1, 1'b0, 1'b0, 1'b0);
      rst1 = 1'b1;
      repeat (2) tick();
      rst1 = 1'b0;
      tick();
      for (int r = 0; r < 4; r++) begin
         sm = 1'($urandom_range(0, 1));
         if (r == 0) sm = 1'b1;
         repeat ($urandom_range(0, 3)) tick();
         go(1, sm);
         if (r == 1) begin
            repeat ($urandom_range(5, 600)) tick();
            rst1 = 1'b1;
            clear_q(1);
            tick();
            rst1 = 1'b0;
            go(1, sm);
         end
         wait_done(1, 20000, sm, 1'b1);
      end
      fin1 = 1'b1;
   end

   // ---------------- summary ----------------
   initial begin
      for (int i = 0; i < 90000 && !(fin0 && fin1); i++) @(posedge clk);
      if (!(fin0 && fin1)) chk("global_timeout", 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
